// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/decode/update sequencer driving the PC select code once per instruction; SEQ_SINGLE_STEP_EN adds step/PAUSE
module pc_sequencer #(
  parameter int IW  = 16,
  parameter int OPW = 4
) (
  input  logic           clk_main,
  input  logic           reset,
  input  logic           run,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic           step,
`endif
  input  logic [IW-1:0]  instr,
  input  logic           instr_valid,
  input  logic           exec_done,
  input  logic           zero_flag,
  input  logic           neg_flag,
  input  logic [OPW-1:0] reg_a_val,
  output logic           fetch_req,
  output logic [IW-1:0]  ir,
  output logic           ir_valid,
  output logic [1:0]     PS,
  output logic [OPW-1:0] offset,
  output logic [OPW-1:0] A,
  output logic           halted
);
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_UPDATE, S_HALT
`ifdef SEQ_SINGLE_STEP_EN
    , S_PAUSE
`endif
  } state_t;
  state_t         r_state, w_next;
  logic [3:0]     w_op;
  logic           w_taken;
  logic [1:0]     w_ps;
  logic [OPW-1:0] w_off, w_a;
  logic           r_fetch_req, r_ir_valid, r_halted;
  logic [IW-1:0]  r_ir;
  logic [1:0]     r_ps;
  logic [OPW-1:0] r_offset, r_a;
  assign w_op      = r_ir[IW-1:IW-4];
  assign fetch_req = r_fetch_req;
  assign ir        = r_ir;
  assign ir_valid  = r_ir_valid;
  assign PS        = r_ps;
  assign offset    = r_offset;
  assign A         = r_a;
  assign halted    = r_halted;
  // next state, plus the PC operands for the coming UPDATE cycle taken from the opcode and live flags in DECODE
  always_comb begin
    w_next  = r_state;
    w_taken = (w_op == 4'hC && zero_flag) || (w_op == 4'hD && neg_flag);
    case (r_state)
      S_IDLE:   w_next = run ? S_FETCH : S_IDLE;
      S_FETCH:  w_next = instr_valid ? S_DECODE : S_FETCH;
      S_DECODE: w_next = (w_op == 4'hF) ? S_HALT : (w_op >= 4'hC) ? S_UPDATE : S_EXEC;
      S_EXEC:   w_next = exec_done ? S_UPDATE : S_EXEC;
`ifdef SEQ_SINGLE_STEP_EN
      S_UPDATE: w_next = S_PAUSE;
      S_PAUSE:  w_next = !run ? S_IDLE : step ? S_FETCH : S_PAUSE;
`else
      S_UPDATE: w_next = run ? S_FETCH : S_IDLE;
`endif
      default:  w_next = r_state;
    endcase
    w_ps  = (w_next != S_UPDATE) ? 2'b00 : (r_state != S_DECODE) ? 2'b01 :
            (w_op == 4'hE) ? 2'b11 : w_taken ? 2'b10 : 2'b01;
    w_off = (w_ps == 2'b10) ? r_ir[OPW-1:0] : '0;
    w_a   = (w_ps == 2'b11) ? reg_a_val : '0;
  end
  // state and registered outputs, each output reflecting the state being entered
  always_ff @(posedge clk_main) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_fetch_req <= 1'b0;
      r_ir        <= '0;
      r_ir_valid  <= 1'b0;
      r_ps        <= 2'b00;
      r_offset    <= '0;
      r_a         <= '0;
      r_halted    <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_fetch_req <= (w_next == S_FETCH);
      r_ir        <= (r_state == S_FETCH && instr_valid) ? instr : r_ir;
      r_ir_valid  <= (w_next == S_DECODE);
      r_ps        <= w_ps;
      r_offset    <= w_off;
      r_a         <= w_a;
      r_halted    <= (w_next == S_HALT);
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed bench with a PC-arithmetic model checked every cycle against pc_sequencer
module tb_pc_sequencer;
  logic        clk, reset, run, instr_valid, exec_done, zero_flag, neg_flag;
  logic [15:0] instr, ir;
  logic [3:0]  reg_a_val, offset, A;
  logic        fetch_req, ir_valid, halted;
  logic [1:0]  PS;
`ifdef SEQ_SINGLE_STEP_EN
  logic        step;
`endif
  int          errors, checks, cyc, ps_cnt, irv_cnt, ps_cyc, pc_acc, pc_base, exp_pc, p_snap;
  logic [1:0]  exp_ps, last_ps;
  logic [3:0]  exp_off, exp_a, last_off, last_a;
  logic [15:0] exp_ir;

  pc_sequencer dut (
    .clk_main(clk), .reset(reset), .run(run),
`ifdef SEQ_SINGLE_STEP_EN
    .step(step),
`endif
    .instr(instr), .instr_valid(instr_valid), .exec_done(exec_done),
    .zero_flag(zero_flag), .neg_flag(neg_flag), .reg_a_val(reg_a_val),
    .fetch_req(fetch_req), .ir(ir), .ir_valid(ir_valid), .PS(PS),
    .offset(offset), .A(A), .halted(halted)
  );

  initial clk = 1'b0;
  // free-running clock
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int pc_now();
    return (pc_base + pc_acc) & 63;
  endfunction

  task automatic set_pc(input int v);
    pc_base = v - pc_acc;
  endtask

  task automatic compare();
    chk("req_and_strobe", {31'd0, fetch_req & ir_valid}, 0);
    if (PS != 2'b00) begin
      ps_cnt++;
      ps_cyc   = cyc;
      last_ps  = PS;
      last_off = offset;
      last_a   = A;
      chk("ps_code", {30'd0, PS}, {30'd0, exp_ps});
      chk("offset", {28'd0, offset}, {28'd0, exp_off});
      chk("a_operand", {28'd0, A}, {28'd0, exp_a});
      pc_acc += (PS == 2'b01) ? 1 : (PS == 2'b10) ? int'(offset) + 1 : int'(A);
    end else begin
      chk("offset_quiet", {28'd0, offset}, 0);
      chk("a_quiet", {28'd0, A}, 0);
    end
    if (ir_valid) begin
      irv_cnt++;
      chk("ir_at_decode", {16'd0, ir}, {16'd0, exp_ir});
    end
    if (halted) begin
      chk("halt_ps", {30'd0, PS}, 0);
      chk("halt_req", {31'd0, fetch_req}, 0);
    end
  endtask

  task automatic tk();
    @(negedge clk);
    cyc++;
    compare();
    #1;
  endtask

  task automatic do_instr(input logic [15:0] w, input logic z, input logic n, input logic [3:0] ra,
                          input int vd, input int ed, input logic rn);
    int p0, v0, t0, k, lat, dlt;
    logic [3:0] op;
    op      = w[15:12];
    p0      = ps_cnt;
    v0      = irv_cnt;
    exp_ir  = w;
    exp_ps  = ((op == 4'hC && z) || (op == 4'hD && n)) ? 2'b10 : (op == 4'hE) ? 2'b11 : 2'b01;
    exp_off = (exp_ps == 2'b10) ? w[3:0] : 4'h0;
    exp_a   = (op == 4'hE) ? ra : 4'h0;
    dlt     = (exp_ps == 2'b10) ? int'(w[3:0]) + 1 : (op == 4'hE) ? int'(ra) : 1;
    lat     = (op >= 4'hC) ? vd + 2 : vd + 3 + ed;
    exp_pc  = (pc_now() + dlt) & 63;
    instr = w; zero_flag = z; neg_flag = n; reg_a_val = ra; run = 1'b1;
`ifdef SEQ_SINGLE_STEP_EN
    step = 1'b1;
`endif
    k = 0;
    while (fetch_req !== 1'b1 && k < 20) begin
      tk();
      k++;
    end
`ifdef SEQ_SINGLE_STEP_EN
    step = 1'b0;
`endif
    chk("fetch_wait", {31'd0, k < 20}, 1);
    t0 = cyc;
    repeat (vd) begin
      tk();
      chk("req_held", {31'd0, fetch_req}, 1);
    end
    instr_valid = 1'b1;
    tk();
    instr_valid = 1'b0;
    chk("decode_strobe", {31'd0, ir_valid}, 1);
    run = rn;
    if (op == 4'hF) return;
    if (op < 4'hC) begin
      instr = ~w;
      instr_valid = 1'b1;
      tk();
      chk("exec_no_ps", {30'd0, PS}, 0);
      repeat (ed) tk();
      exec_done = 1'b1;
    end
    tk();
    exec_done = 1'b0; instr_valid = 1'b0; instr = w;
    chk("one_ps_pulse", ps_cnt - p0, 1);
    chk("one_decode", irv_cnt - v0, 1);
    chk("latency", ps_cyc - t0, lat);
    chk("pc_model", pc_now(), exp_pc);
    chk("ir_held", {16'd0, ir}, {16'd0, w});
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0; ps_cnt = 0; irv_cnt = 0; ps_cyc = 0; pc_acc = 0; pc_base = 0;
    exp_ps = 2'b01; exp_off = 0; exp_a = 0; exp_ir = 0; exp_pc = 0; last_ps = 0; last_off = 0; last_a = 0;
    reset = 1'b1; run = 1'b1; instr = 16'hF000; instr_valid = 1'b1; exec_done = 1'b1;
    zero_flag = 1'b1; neg_flag = 1'b1; reg_a_val = 4'hF;
`ifdef SEQ_SINGLE_STEP_EN
    step = 1'b1;
`endif
    repeat (3) begin
      tk();
      chk("rst_fetch_req", {31'd0, fetch_req}, 0);
      chk("rst_ir", {16'd0, ir}, 0);
      chk("rst_ir_valid", {31'd0, ir_valid}, 0);
      chk("rst_ps", {30'd0, PS}, 0);
      chk("rst_offset", {28'd0, offset}, 0);
      chk("rst_a", {28'd0, A}, 0);
      chk("rst_halted", {31'd0, halted}, 0);
    end
    reset = 1'b0; run = 1'b0; instr_valid = 1'b0; exec_done = 1'b0; zero_flag = 1'b0; neg_flag = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    step = 1'b0;
`endif
    tk();
    chk("idle_no_req", {31'd0, fetch_req}, 0);

    set_pc(0);
    do_instr(16'h1234, 1'b0, 1'b0, 4'h0, 2, 0, 1'b1);
    chk("alu_ir", {16'd0, ir}, 32'h1234);
    chk("alu_ps", {30'd0, last_ps}, 1);
    chk("alu_pc", pc_now(), 1);

    set_pc(10);
    do_instr(16'hC005, 1'b1, 1'b0, 4'h0, 0, 0, 1'b1);
    chk("bz_taken_ps", {30'd0, last_ps}, 2);
    chk("bz_taken_off", {28'd0, last_off}, 5);
    chk("bz_taken_pc", pc_now(), 16);
    do_instr(16'hC005, 1'b0, 1'b0, 4'h0, 0, 0, 1'b1);
    chk("bz_not_ps", {30'd0, last_ps}, 1);
    chk("bz_not_pc", pc_now(), 17);
    do_instr(16'hD003, 1'b0, 1'b1, 4'h0, 1, 0, 1'b1);
    chk("bn_taken_pc", pc_now(), 21);
    do_instr(16'hD003, 1'b1, 1'b0, 4'h0, 0, 0, 1'b1);
    chk("bn_not_ps", {30'd0, last_ps}, 1);
    chk("bn_not_pc", pc_now(), 22);

    set_pc(60);
    do_instr(16'hE000, 1'b0, 1'b0, 4'hF, 1, 0, 1'b1);
    chk("jr_ps", {30'd0, last_ps}, 3);
    chk("jr_a", {28'd0, last_a}, 15);
    chk("jr_wrap_pc", pc_now(), 11);

`ifdef SEQ_SINGLE_STEP_EN
    p_snap = ps_cnt;
    repeat (5) begin
      tk();
      chk("pause_holds", {31'd0, fetch_req}, 0);
    end
    do_instr(16'h2001, 1'b0, 1'b0, 4'h0, 0, 0, 1'b1);
    do_instr(16'hC002, 1'b0, 1'b0, 4'h0, 0, 0, 1'b1);
    chk("two_steps_two_updates", ps_cnt - p_snap, 2);
    repeat (3) tk();
    chk("pause_after_steps", ps_cnt - p_snap, 2);
`endif

    do_instr(16'h2000, 1'b0, 1'b0, 4'h0, 1, 2, 1'b0);
    p_snap = ps_cnt;
    exec_done = 1'b1;
    repeat (4) begin
      tk();
      chk("run_drop_idle", {31'd0, fetch_req}, 0);
    end
    exec_done = 1'b0;
    chk("exec_done_ignored", ps_cnt - p_snap, 0);

    run = 1'b1; instr = 16'h3000; exp_ir = 16'h3000;
    for (int k = 0; k < 20 && fetch_req !== 1'b1; k++) tk();
    chk("rst_exec_fetch", {31'd0, fetch_req}, 1);
    instr_valid = 1'b1;
    tk();
    instr_valid = 1'b0;
    tk();
    p_snap = ps_cnt;
    exec_done = 1'b1; reset = 1'b1;
    tk();
    chk("rst_exec_ps", {30'd0, PS}, 0);
    chk("rst_exec_ir", {16'd0, ir}, 0);
    chk("rst_exec_no_pulse", ps_cnt - p_snap, 0);
    reset = 1'b0; exec_done = 1'b0; run = 1'b0;
    tk();
    chk("rst_exec_idle", {31'd0, fetch_req}, 0);
    chk("rst_exec_still_none", ps_cnt - p_snap, 0);
    run = 1'b1;
    tk();
    chk("idle_to_fetch", {31'd0, fetch_req}, 1);

    do_instr(16'hF000, 1'b0, 1'b0, 4'h0, 0, 0, 1'b1);
    tk();
    chk("halt_set", {31'd0, halted}, 1);
    p_snap = ps_cnt;
    for (int k = 0; k < 20; k++) begin
      instr_valid = k[0];
      exec_done = 1'b1;
      tk();
      chk("halt_stays", {31'd0, halted}, 1);
      chk("halt_ps_zero", {30'd0, PS}, 0);
    end
    chk("halt_no_pulse", ps_cnt - p_snap, 0);
    reset = 1'b1;
    tk();
    chk("halt_cleared", {31'd0, halted}, 0);
    reset = 1'b0; run = 1'b0; exec_done = 1'b0; instr_valid = 1'b0;
    tk();
    chk("post_halt_idle", {31'd0, fetch_req | halted}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
